// File: rtl/uart_onchip_memory_dp.sv
// True-dual-port RAM with two Avalon-MM slave ports, byte enables and a post-reset clear sequencer.
// Read latency 1 cycle (2 with OUT_REG); waitrequest is high only while initialising or when clken is low.
module uart_onchip_memory_dp #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 12,
   parameter int                    DEPTH          = 4096,
   parameter int                    OUT_REG        = 0,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clken,
   input  logic [ADDR_WIDTH-1:0]   s1_address,
   input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
   input  logic                    s1_chipselect,
   input  logic                    s1_read,
   input  logic                    s1_write,
   input  logic [DATA_WIDTH-1:0]   s1_writedata,
   output logic [DATA_WIDTH-1:0]   s1_readdata,
   output logic                    s1_readdatavalid,
   output logic                    s1_waitrequest,
   input  logic [ADDR_WIDTH-1:0]   s2_address,
   input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
   input  logic                    s2_chipselect,
   input  logic                    s2_read,
   input  logic                    s2_write,
   input  logic [DATA_WIDTH-1:0]   s2_writedata,
   output logic [DATA_WIDTH-1:0]   s2_readdata,
   output logic                    s2_readdatavalid,
   output logic                    s2_waitrequest,
   output logic                    init_busy
);

   localparam int                  BE_W     = DATA_WIDTH / 8;
   localparam int                  IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [IW-1:0]       LAST_IDX = IW'(DEPTH - 1);

   localparam logic [1:0] ST_RESET = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   logic [1:0]            state;
   logic [IW-1:0]         clr_addr;
   logic                  clr_we;
   logic                  ready;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // index 0 is s1, index 1 is s2
   logic [ADDR_WIDTH-1:0] addr [2];
   logic [BE_W-1:0]       be   [2];
   logic [DATA_WIDTH-1:0] wdat [2];
   logic [1:0]            cs, rd, wr;
   logic [1:0]            acc, rd_acc, wr_acc, in_rng;

   logic [1:0]            v1, v2;
   logic [DATA_WIDTH-1:0] d1 [2];
   logic [DATA_WIDTH-1:0] d2 [2];

   assign addr[0] = s1_address;
   assign addr[1] = s2_address;
   assign be[0]   = s1_byteenable;
   assign be[1]   = s2_byteenable;
   assign wdat[0] = s1_writedata;
   assign wdat[1] = s2_writedata;
   assign cs      = {s2_chipselect, s1_chipselect};
   assign rd      = {s2_read, s1_read};
   assign wr      = {s2_write, s1_write};

   assign ready   = (state == ST_READY);
   assign clr_we  = reset_n & clken & (state == ST_CLEAR);

   always_comb begin
      acc    = '0;
      rd_acc = '0;
      wr_acc = '0;
      in_rng = '0;
      for (int p = 0; p < 2; p++) begin
         acc[p]    = cs[p] & (rd[p] | wr[p]) & ready & clken;
         wr_acc[p] = acc[p] & wr[p];
         rd_acc[p] = acc[p] & rd[p] & ~wr[p];
         in_rng[p] = ({1'b0, addr[p]} < DEPTH_W);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_RESET;
         clr_addr <= '0;
      end else if (clken) begin
         case (state)
            ST_RESET: begin
               clr_addr <= '0;
               state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
               if (clr_addr == LAST_IDX) state <= ST_READY;
               else                      clr_addr <= clr_addr + 1'b1;
            end
            default: state <= ST_READY;
         endcase
      end
   end

   // s2 lanes are written first so that s1 lanes override on a same-address collision
   always_ff @(posedge clk) begin
      if (clr_we) mem[clr_addr] <= CLEAR_VALUE;
      for (int p = 1; p >= 0; p--) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_acc[p] && in_rng[p] && be[p][b])
               mem[addr[p][IW-1:0]][b*8 +: 8] <= wdat[p][b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v1 <= '0;
         v2 <= '0;
         for (int p = 0; p < 2; p++) begin
            d1[p] <= '0;
            d2[p] <= '0;
         end
      end else if (clken) begin
         for (int p = 0; p < 2; p++) begin
            v1[p] <= rd_acc[p];
            if (rd_acc[p]) d1[p] <= in_rng[p] ? mem[addr[p][IW-1:0]] : '0;
            v2[p] <= v1[p];
            if (v1[p]) d2[p] <= d1[p];
         end
      end
   end

   assign s1_readdata      = (OUT_REG != 0) ? d2[0] : d1[0];
   assign s2_readdata      = (OUT_REG != 0) ? d2[1] : d1[1];
   assign s1_readdatavalid = (OUT_REG != 0) ? v2[0] : v1[0];
   assign s2_readdatavalid = (OUT_REG != 0) ? v2[1] : v1[1];
   assign s1_waitrequest   = ~ready | ~clken;
   assign s2_waitrequest   = ~ready | ~clken;
   assign init_busy        = ~ready;

endmodule

// File: doc/uart_onchip_memory_dp.md
# uart_onchip_memory_dp

Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2), pipelined reads with `readdatavalid`, per-byte write enables, an optional output register and a post-reset clear sequencer. It replaces the fixed 4096×32 single-port program/data memory in the UART subsystem. The second port lets a DMA or debug master access the RAM alongside the CPU.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; must be a multiple of 8.
- `ADDR_WIDTH`, 12: word-address width.
- `DEPTH`, 4096: number of words; must be ≤ 2**`ADDR_WIDTH`.
- `OUT_REG`, 0: 1 adds an output register stage, so read latency is 2 instead of 1.
- `CLEAR_ON_RESET`, 1: 1 clears the whole RAM after reset.
- `CLEAR_VALUE`, 0: word written to every location during clear.

Ports (`sX` = `s1` and `s2`, identical sets):
- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `clken`  in  1  global clock enable; low freezes the block.
- `sX_address`  in  ADDR_WIDTH  word address.
- `sX_byteenable`  in  DATA_WIDTH/8  byte lane enables for writes.
- `sX_chipselect`  in  1  port select.
- `sX_read`  in  1  read request.
- `sX_write`  in  1  write request.
- `sX_writedata`  in  DATA_WIDTH  write data.
- `sX_readdata`  out  DATA_WIDTH  read data; valid when `sX_readdatavalid` is high.
- `sX_readdatavalid`  out  1  one-cycle strobe per accepted read.
- `sX_waitrequest`  out  1  high means the request is not accepted.
- `init_busy`  out  1  high while in reset or while clearing.

## Operation
- FSM states: RESET → CLEAR → READY.
  - `reset_n` low forces RESET, from any state.
  - First cycle with `reset_n` high: go to CLEAR if `CLEAR_ON_RESET`=1, else to READY.
  - CLEAR: an internal counter writes `CLEAR_VALUE` to addresses 0..DEPTH-1, one word per enabled cycle. After address DEPTH-1 is written, go to READY.
  - Reset during CLEAR restarts the clear at address 0.
- Request acceptance: a request on a port is accepted when `chipselect` & (`read` | `write`) & ~`waitrequest` & `clken`.
- `sX_waitrequest` = ~(state==READY) | ~`clken`. In READY with `clken` high there is no backpressure.
- Writes:
  - Only lanes with `byteenable[i]`=1 are updated.
  - `read` and `write` both high on one port: the write is performed and no read is issued (no `readdatavalid`).
- Reads: every accepted read produces exactly one `readdatavalid` pulse, in order.
- Collisions:
  - Both ports write the same address in the same cycle: s1's enabled lanes win. s2 updates only lanes that s1 does not enable.
  - Read during write, same port or other port, same address and same cycle: the read returns old data.
- Out-of-range address (≥ DEPTH): writes are dropped; reads return 0 and still assert `readdatavalid`.
- `clken` low:
  - No accesses are accepted.
  - The clear counter holds.
  - The read pipeline (data and valid) holds its contents, and outputs stay stable.

## Timing
- Reset values: `sX_readdata`=0, `sX_readdatavalid`=0, `sX_waitrequest`=1, `init_busy`=1.
- Read latency, in enabled cycles, counted from the acceptance edge:
  - `OUT_REG`=0: `readdatavalid` is high in cycle N+1.
  - `OUT_REG`=1: `readdatavalid` is high in cycle N+2.
- Throughput: one read or write per port per enabled cycle. Back-to-back reads give back-to-back valids.
- Write-then-read to the same address in consecutive cycles returns the new data.
- Clear duration: exactly DEPTH enabled cycles in CLEAR.
  - `init_busy` and `waitrequest` drop in the first cycle of READY.
  - Without `clken` stalls, that is DEPTH+1 cycles after the reset release edge.
- `readdatavalid` is cleared by reset. Reads in flight at reset are lost.
- `readdata` holds its last value while `readdatavalid` is low.

## Test plan
- Clear check:
  - Stimulus: DEPTH=16, `CLEAR_VALUE`=32'hA5A5A5A5; release reset, then read all 16 addresses on s2.
  - Required response: `init_busy` falls 17 cycles after the release edge, and all 16 reads return A5A5A5A5.
- Byte lanes:
  - Stimulus: s1 writes 32'h11223344 to address 5 with `byteenable`=4'b0101 over an A5A5A5A5 word; s2 reads address 5.
  - Required response: read returns A522A544, with latency 1 (`OUT_REG`=0) or 2 (`OUT_REG`=1).
- Dual-write collision:
  - Stimulus: in the same cycle, s1 writes 0xFFFFFFFF to address 3 with be=4'b0011, and s2 writes 0x12345678 to address 3 with be=4'b1111.
  - Required response: a later read of address 3 returns 1234FFFF.
- Mixed read-during-write:
  - Stimulus: s2 reads address 7 (old value 0) in the same cycle that s1 writes 0xDEADBEEF to address 7.
  - Required response: s2 gets 0. A read in the next cycle gets DEADBEEF.
- `clken` stall with reads in flight (`OUT_REG`=1):
  - Stimulus: issue 4 back-to-back reads, then drop `clken` for 3 cycles.
  - Required response: `waitrequest`=1 during the stall, `readdatavalid`/`readdata` frozen, and all 4 valids delivered in order after `clken` returns.
- Reset mid-clear:
  - Stimulus: assert `reset_n`=0 at clear address 9 for 1 cycle.
  - Required response: clear restarts at address 0, and `init_busy` falls DEPTH+1 cycles after the second release.
